nv_blkbox_src_lfsr: RTL
=======================

# nv_blkbox_src_lfsr

Pseudo-random stream source that drives a valid/ready payload interface into a black-box sink or any downstream consumer under test. It is the producing end of the sink path. It replaces a constant tie-off with a programmable, reproducible LFSR sequence of a configured length. It sits on the core clock domain next to the black-box sinks and is used for bring-up and DFT observation of otherwise unloaded ports.

## Interface
- WIDTH, 16, payload width in bits (minimum 2)
- POLY, 16'h6801, Galois feedback mask (x^16+x^14+x^13+x^11+1, maximal length for WIDTH=16)
- nvdla_core_clk  input  1  core clock, all state on rising edge
- nvdla_core_rstn  input  1  reset, asynchronous and active-low
- cfg_en  input  1  level enable: start a run, and keep it running
- cfg_seed  input  WIDTH  initial LFSR value, sampled at start
- cfg_len  input  16  number of beats to emit, sampled at start
- src_pvld  output  1  payload valid
- src_prdy  input  1  downstream ready
- src_pd  output  WIDTH  payload
- busy  output  1  high while in RUN
- done  output  1  high in DONE state
- beat_cnt  output  16  beats accepted in the current or last run

## Operation
- States: IDLE, RUN, DONE. Reset state is IDLE.
- Reset values: src_pvld=0, src_pd=0, busy=0, done=0, beat_cnt=0, LFSR=0, remaining=0.
- IDLE -> RUN when cfg_en=1 and cfg_len!=0.
  - Loads LFSR=cfg_seed. If cfg_seed==0, it loads 1.
  - Loads remaining=cfg_len and clears beat_cnt.
- IDLE -> DONE when cfg_en=1 and cfg_len==0. Nothing is emitted and beat_cnt is cleared.
- RUN: src_pvld=1 and src_pd=LFSR.
- A beat is accepted on a cycle with src_pvld&&src_prdy.
  - LFSR_next = {LFSR[WIDTH-2:0],1'b0} ^ (LFSR[WIDTH-1] ? POLY : 0).
  - remaining decrements and beat_cnt increments. beat_cnt saturates at 16'hFFFF.
- RUN -> DONE on acceptance when remaining==1.
- RUN with cfg_en=0:
  - An offered beat is never withdrawn. src_pvld stays 1 until that beat is accepted.
  - On that acceptance the block goes to IDLE, not DONE, and done stays 0.
  - The accepted beat is counted in beat_cnt.
- DONE: done=1 and src_pvld=0. DONE -> IDLE when cfg_en=0. The run parameters are not re-sampled while in DONE.
- cfg_seed and cfg_len changes during RUN or DONE are ignored.
- src_pd is driven from the LFSR register only in RUN. It is 0 in IDLE and DONE.

## Timing
- Start latency: cfg_en sampled high in IDLE at edge N gives src_pvld=1 with src_pd=seed after edge N.
- Back-pressure:
  - While src_pvld&&!src_prdy, src_pd and src_pvld hold stable.
  - With src_prdy held high, one beat per cycle, with no bubbles.
- After the last acceptance at edge M: src_pvld=0 and done=1 after edge M, and busy=0.
- Abort: a beat accepted at edge M with cfg_en=0 gives state IDLE after edge M, with src_pvld=0.
- Restart after DONE takes at least 2 cycles: cfg_en low for one sampled edge, then high.
- Asynchronous reset at any point, including mid-beat, forces all outputs to reset values immediately. The beat in flight is dropped.
- All outputs are registered. There is no combinational path from src_prdy to src_pvld or src_pd.

## Test plan
- Basic run: seed=16'h0001, len=4, prdy=1 -> pd sequence 0x0001, 0x0002, 0x0004, 0x0008 on consecutive cycles. done=1 the cycle after the 4th beat, and beat_cnt=4.
- Feedback: seed=16'h8000, len=2 -> pd 0x8000, then 0x6801.
- Back-pressure: seed=16'h0001, len=3, prdy toggling 0,0,1,0,1,1 -> pd holds 0x0001 through both stall cycles. Exactly 3 beats are accepted (0x0001, 0x0002, 0x0004) and pvld never drops while a beat is unaccepted.
- Zero and degenerate config:
  - len=0 -> DONE the cycle after enable, no pvld, beat_cnt=0.
  - seed=0, len=2 -> pd 0x0001, 0x0002.
- Abort: len=10, drop cfg_en after the 2nd acceptance while prdy=0 for 3 cycles.
  - The 3rd beat (0x0004) stays valid until accepted.
  - Then IDLE, done=0, beat_cnt=3.
- Reset mid-run: assert nvdla_core_rstn=0 asynchronously while pvld=1 and prdy=0 -> src_pvld, done, busy and beat_cnt are 0 immediately. After release with cfg_en=1 the run restarts from the seed.

Source files
------------

// File: rtl/nv_blkbox_src_lfsr_if.sv
// Valid/ready payload channel between the LFSR source
// and a downstream consumer.
interface nv_blkbox_src_lfsr_if #(
  parameter int WIDTH = 16
);
  logic             src_pvld;
  logic             src_prdy;
  logic [WIDTH-1:0] src_pd;

  modport master (
    output src_pvld,
    output src_pd,
    input  src_prdy
  );

  modport slave (
    input  src_pvld,
    input  src_pd,
    output src_prdy
  );
endinterface

// File: rtl/nv_blkbox_src_lfsr.sv
// Reproducible Galois-LFSR payload source that emits a
// configured number of beats on a valid/ready channel.
module nv_blkbox_src_lfsr #(
  parameter int             WIDTH = 16,
  parameter logic [WIDTH-1:0] POLY = WIDTH'(16'h6801)
) (
  input  logic                 nvdla_core_clk,
  input  logic                 nvdla_core_rstn,
  input  logic                 cfg_en,
  input  logic [WIDTH-1:0]     cfg_seed,
  input  logic [15:0]          cfg_len,
  nv_blkbox_src_lfsr_if.master src,
  output logic                 busy,
  output logic                 done,
  output logic [15:0]          beat_cnt
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] lfsr_q, lfsr_d;
  logic [15:0]      rem_q, rem_d;
  logic [15:0]      cnt_q, cnt_d;
  logic [WIDTH-1:0] lfsr_step;
  logic             accept;

  assign accept = (state_q == RUN) && src.src_prdy;
  assign lfsr_step = {lfsr_q[WIDTH-2:0], 1'b0}
                   ^ (lfsr_q[WIDTH-1] ? POLY : '0);

  always_comb begin
    state_d = state_q;
    lfsr_d  = lfsr_q;
    rem_d   = rem_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (cfg_en) begin
          cnt_d = '0;
          if (cfg_len != 16'd0) begin
            state_d = RUN;
            rem_d   = cfg_len;
            // an all-zero seed would lock the LFSR
            lfsr_d  = (cfg_seed == '0) ? WIDTH'(1)
                                       : cfg_seed;
          end else begin
            state_d = DONE;
          end
        end
      end
      RUN: begin
        if (accept) begin
          lfsr_d = lfsr_step;
          rem_d  = rem_q - 16'd1;
          if (cnt_q != 16'hFFFF)
            cnt_d = cnt_q + 16'd1;
          if (!cfg_en)
            state_d = IDLE;
          else if (rem_q == 16'd1)
            state_d = DONE;
        end
      end
      DONE: begin
        if (!cfg_en)
          state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      state_q <= IDLE;
      lfsr_q  <= '0;
      rem_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      lfsr_q  <= lfsr_d;
      rem_q   <= rem_d;
      cnt_q   <= cnt_d;
    end
  end

  assign src.src_pvld = (state_q == RUN);
  assign src.src_pd   = (state_q == RUN) ? lfsr_q : '0;
  assign busy         = (state_q == RUN);
  assign done         = (state_q == DONE);
  assign beat_cnt     = cnt_q;

endmodule
